// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter for single-ported 64Kx16 mem; optional store protection via MEM_ARB_WPROT_EN
module mem_arb #(
    parameter int          STARVE_LIMIT = 4,
    parameter int unsigned WPROT_TOP    = 16'h0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_f_req,
    input  logic [15:0] i_f_addr,
    output logic        o_f_gnt,
    output logic        o_f_rvalid,
    output logic [15:0] o_f_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [15:0] i_d_addr,
    input  logic [15:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [15:0] o_d_rdata,
    output logic        o_d_err,
    output logic [15:0] o_m_addr,
    output logic [15:0] o_m_st_data,
    input  logic [15:0] i_m_ld_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    // Reject out-of-range configurations at elaboration.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || WPROT_TOP > 32'h0001_0000) begin : g_bad_param
        $error("mem_arb: STARVE_LIMIT must be 1..15 and WPROT_TOP at most 0x10000");
    end

    logic [SW-1:0] r_streak;
    logic          r_f_rvalid;
    logic [15:0]   r_f_rdata;
    logic          r_d_rvalid;
    logic [15:0]   r_d_rdata;

    logic          w_starved;
    logic          w_f_gnt;
    logic          w_d_gnt;
    logic          w_wprot_hit;
    logic [15:0]   w_m_addr;
    logic [15:0]   w_m_st_data;

    // Fetch wins a contended cycle only once the data port has used up its streak.
    always_comb begin
        w_starved = (r_streak == STREAK_MAX);
        w_f_gnt   = 1'b0;
        w_d_gnt   = 1'b0;
        if (!i_rst) begin
            w_f_gnt = i_f_req && (!i_d_req || w_starved);
            w_d_gnt = i_d_req && !(i_f_req && w_starved);
        end
    end

`ifdef MEM_ARB_WPROT_EN
    // A granted store into the protected low region still consumes the slot but is turned into a no-op.
    always_comb begin
        w_wprot_hit = w_d_gnt && i_d_we && ({16'h0000, i_d_addr} < WPROT_TOP);
    end
`else
    // Without protection no store is ever rejected.
    always_comb begin
        w_wprot_hit = 1'b0;
    end
`endif

    // mem writes every clock, so non-store cycles loop read data back and idle parks on address 0.
    always_comb begin
        w_m_addr    = 16'h0000;
        w_m_st_data = 16'h0000;
        if (w_f_gnt) begin
            w_m_addr    = i_f_addr;
            w_m_st_data = i_m_ld_data;
        end else if (w_d_gnt && !w_wprot_hit) begin
            w_m_addr    = i_d_addr;
            w_m_st_data = i_d_we ? i_d_wdata : i_m_ld_data;
        end
    end

    // Count consecutive data wins while fetch waits; saturate so fetch is forced through.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_streak <= '0;
        end else if (w_f_gnt || !i_f_req) begin
            r_streak <= '0;
        end else if (w_d_gnt && !w_starved) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    // Fetch response: one-cycle valid pulse, data held between grants.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= 16'h0000;
        end else begin
            r_f_rvalid <= w_f_gnt;
            if (w_f_gnt) begin
                r_f_rdata <= i_m_ld_data;
            end
        end
    end

    // Data response: load data or zero on store acknowledge, held between grants.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= 16'h0000;
        end else begin
            r_d_rvalid <= w_d_gnt;
            if (w_d_gnt) begin
                r_d_rdata <= i_d_we ? 16'h0000 : i_m_ld_data;
            end
        end
    end

`ifdef MEM_ARB_WPROT_EN
    logic r_d_err;

    // Error flag travels with the acknowledge of a rejected store.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_err <= 1'b0;
        end else begin
            r_d_err <= w_wprot_hit;
        end
    end

    assign o_d_err = r_d_err;
`else
    assign o_d_err = w_wprot_hit;
`endif

    assign o_f_gnt     = w_f_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_m_addr    = w_m_addr;
    assign o_m_st_data = w_m_st_data;
    assign o_f_rvalid  = r_f_rvalid;
    assign o_f_rdata   = r_f_rdata;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb with behavioural 64Kx16 mem
`timescale 1ns/1ps
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        d_err;
    logic [15:0] m_addr;
    logic [15:0] m_st_data;
    logic [15:0] m_ld_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] f_q[$];
    logic [16:0] d_q[$];
    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;

    mem_arb #(.STARVE_LIMIT(4), .WPROT_TOP(16'h0100)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
        .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
        .o_m_addr(m_addr), .o_m_st_data(m_st_data), .i_m_ld_data(m_ld_data)
    );

    // mem: combinational read, stores st_data every clock, address 0 reads 0 and ignores writes
    assign m_ld_data = (m_addr == 16'h0000) ? 16'h0000 : mem[m_addr];
    always @(posedge clk) begin
        if (m_addr != 16'h0000) mem[m_addr] <= m_st_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pop expected responses whenever the DUT presents one
    always @(negedge clk) begin
        if (f_rvalid) begin
            if (f_q.size() == 0) chk("f_rvalid_unexpected", 32'd1, 32'd0);
            else chk("f_rdata", {16'h0, f_rdata}, {16'h0, f_q.pop_front()});
        end
        if (d_rvalid) begin
            if (d_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
            else chk("d_rdata_err", {15'h0, d_err, d_rdata}, {15'h0, d_q.pop_front()});
        end
    end

    // One cycle of stimulus; checks combinational outputs and queues expected responses
    task automatic drive(input logic fr, input logic [15:0] fa,
                         input logic dr, input logic we, input logic [15:0] da, input logic [15:0] wd,
                         input logic eg_f, input logic eg_d,
                         input logic [15:0] e_maddr, input logic [15:0] e_mst,
                         input logic [15:0] e_f, input logic [15:0] e_d, input logic e_err);
        f_req = fr; f_addr = fa; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        @(negedge clk);
        chk("f_gnt", {31'h0, f_gnt}, {31'h0, eg_f});
        chk("d_gnt", {31'h0, d_gnt}, {31'h0, eg_d});
        chk("m_addr", {16'h0, m_addr}, {16'h0, e_maddr});
        chk("m_st_data", {16'h0, m_st_data}, {16'h0, e_mst});
        if (eg_f) f_q.push_back(e_f);
        if (eg_d) d_q.push_back({e_err, e_d});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hC3C3;

        // Reset: outputs quiet even with both requests pending
        f_req = 1; f_addr = 16'h0400; d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h9999;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_f_gnt", {31'h0, f_gnt}, 32'd0);
        chk("rst_d_gnt", {31'h0, d_gnt}, 32'd0);
        chk("rst_m_addr", {16'h0, m_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Idle after reset: all registered outputs zero, mem parked
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("idle_outs", {f_rvalid, d_rvalid, d_err, f_rdata, d_rdata}, 32'd0);
        end

        // Store then load / fetch the same address
        drive(0, 16'h0, 1, 1, 16'h0200, 16'h1234, 0, 1, 16'h0200, 16'h1234, 16'h0, 16'h0000, 0);
        drive(0, 16'h0, 1, 0, 16'h0200, 16'h0,    0, 1, 16'h0200, 16'h1234, 16'h0, 16'h1234, 0);
        drive(1, 16'h0200, 0, 0, 16'h0, 16'h0,    1, 0, 16'h0200, 16'h1234, 16'h1234, 16'h0, 0);
        drive(1, 16'h0200, 0, 0, 16'h0, 16'h0,    1, 0, 16'h0200, 16'h1234, 16'h1234, 16'h0, 0);
        drive(0, 16'h0, 1, 0, 16'h0200, 16'h0,    0, 1, 16'h0200, 16'h1234, 16'h0, 16'h1234, 0);
        drive(0, 16'h0, 1, 0, 16'h0300, 16'h0,    0, 1, 16'h0300, 16'hC0C3, 16'h0, 16'hC0C3, 0);

        // Both ports saturated: D,D,D,D,F repeating
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                drive(1, 16'h0400, 1, 0, 16'h0500, 16'h0, 1, 0, 16'h0400, 16'hC7C3, 16'hC7C3, 16'h0, 0);
            else
                drive(1, 16'h0400, 1, 0, 16'h0500, 16'h0, 0, 1, 16'h0500, 16'hC6C3, 16'h0, 16'hC6C3, 0);
        end
        idle();

        // Reset pulse during a store: no grant, no write, no response
        rst = 1;
        drive(0, 16'h0, 1, 1, 16'h0300, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 16'h0, 16'h0, 0);
        rst = 0;
        idle();
        chk("rst_mid_d_rvalid", {31'h0, d_rvalid}, 32'd0);
        drive(0, 16'h0, 1, 0, 16'h0300, 16'h0, 0, 1, 16'h0300, 16'hC0C3, 16'h0, 16'hC0C3, 0);

        // Address 0 store is acknowledged but discarded
        drive(0, 16'h0, 1, 1, 16'h0000, 16'hFFFF, 0, 1, 16'h0000, 16'hFFFF, 16'h0, 16'h0000, 0);
        drive(0, 16'h0, 1, 0, 16'h0000, 16'h0,    0, 1, 16'h0000, 16'h0000, 16'h0, 16'h0000, 0);

`ifdef MEM_ARB_WPROT_EN
        // Protected store rejected; boundary address writable
        drive(0, 16'h0, 1, 1, 16'h0050, 16'hAAAA, 0, 1, 16'h0000, 16'h0000, 16'h0, 16'h0000, 1);
        drive(0, 16'h0, 1, 0, 16'h0050, 16'h0,    0, 1, 16'h0050, 16'hC393, 16'h0, 16'hC393, 0);
        drive(0, 16'h0, 1, 1, 16'h0100, 16'h5555, 0, 1, 16'h0100, 16'h5555, 16'h0, 16'h0000, 0);
        drive(0, 16'h0, 1, 0, 16'h0100, 16'h0,    0, 1, 16'h0100, 16'h5555, 16'h0, 16'h5555, 0);
`else
        // No protection: low stores land normally
        drive(0, 16'h0, 1, 1, 16'h0050, 16'h7777, 0, 1, 16'h0050, 16'h7777, 16'h0, 16'h0000, 0);
        drive(0, 16'h0, 1, 0, 16'h0050, 16'h0,    0, 1, 16'h0050, 16'h7777, 16'h0, 16'h7777, 0);
`endif

        idle();
        idle();
        chk("f_q_drained", f_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
